// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter: CPU and debug/loader share one synchronous RAM.
// Fixed three-cycle access (IDLE/ACCESS/RESP), CPU priority with a debug anti-starvation limit.
module ram_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_wait
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic              OWN_CPU = 1'b0;
  localparam logic              OWN_DBG = 1'b1;

  state_t              state_r;
  state_t              state_next_s;
  logic                owner_r;
  logic                we_r;
  logic [CNT_W-1:0]    starve_cnt_r;
  logic                cpu_win_s;
  logic                dbg_win_s;
  logic                grant_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                ram_read_r;
  logic                ram_write_r;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [DATA_W-1:0]   ram_wdata_r;
  logic                cpu_ack_r;
  logic                dbg_ack_r;
  logic [DATA_W-1:0]   cpu_hold_r;
  logic [DATA_W-1:0]   dbg_hold_r;
  logic [DATA_W-1:0]   cpu_rdata_s;
  logic [DATA_W-1:0]   dbg_rdata_s;
  logic                cpu_wait_s;

  // Arbitration: CPU wins ties unless debug has waited STARVE_LIMIT CPU grants.
  always_comb begin
    cpu_win_s = 1'b0;
    dbg_win_s = 1'b0;
    if (state_r == IDLE && !clr) begin
      if (cpu_req && (!dbg_req || starve_cnt_r != LIMIT_C)) begin
        cpu_win_s = 1'b1;
      end else if (dbg_req) begin
        dbg_win_s = 1'b1;
      end else begin
        cpu_win_s = 1'b0;
        dbg_win_s = 1'b0;
      end
    end else begin
      cpu_win_s = 1'b0;
      dbg_win_s = 1'b0;
    end
    grant_s = cpu_win_s | dbg_win_s;
    if (dbg_win_s) begin
      sel_we_s    = dbg_we;
      sel_addr_s  = dbg_addr;
      sel_wdata_s = dbg_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; clr aborts whatever is in flight.
  always_comb begin
    state_next_s = IDLE;
    if (clr) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_next_s = grant_s ? ACCESS : IDLE;
        ACCESS:  state_next_s = RESP;
        RESP:    state_next_s = IDLE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Grant capture, RAM strobes and acks; acks only when ACCESS proceeds into RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r     <= OWN_CPU;
      we_r        <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_read_r  <= 1'b0;
      ram_write_r <= 1'b0;
      cpu_ack_r   <= 1'b0;
      dbg_ack_r   <= 1'b0;
    end else begin
      if (grant_s) begin
        owner_r     <= dbg_win_s;
        we_r        <= sel_we_s;
        ram_addr_r  <= sel_addr_s;
        ram_wdata_r <= sel_wdata_s;
      end else begin
        owner_r     <= owner_r;
        we_r        <= we_r;
        ram_addr_r  <= ram_addr_r;
        ram_wdata_r <= ram_wdata_r;
      end
      ram_read_r  <= grant_s & ~sel_we_s;
      ram_write_r <= grant_s & sel_we_s;
      cpu_ack_r   <= (state_next_s == RESP) && (owner_r == OWN_CPU);
      dbg_ack_r   <= (state_next_s == RESP) && (owner_r == OWN_DBG);
    end
  end

  // Starvation counter, only meaningful while debug is actually waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= '0;
    end else if (clr) begin
      starve_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      if (dbg_win_s || !dbg_req) begin
        starve_cnt_r <= '0;
      end else if (cpu_win_s && starve_cnt_r != LIMIT_C) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Read-data hold registers, captured as a read leaves RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_hold_r <= '0;
      dbg_hold_r <= '0;
    end else if (state_r == RESP && !we_r && !clr) begin
      if (owner_r == OWN_DBG) begin
        dbg_hold_r <= ram_rdata;
      end else begin
        cpu_hold_r <= ram_rdata;
      end
    end else begin
      cpu_hold_r <= cpu_hold_r;
      dbg_hold_r <= dbg_hold_r;
    end
  end

  // Output decode: RAM data passes straight through in the owner's RESP cycle.
  always_comb begin
    cpu_rdata_s = cpu_hold_r;
    dbg_rdata_s = dbg_hold_r;
    if (state_r == RESP && !we_r) begin
      if (owner_r == OWN_DBG) begin
        dbg_rdata_s = ram_rdata;
      end else begin
        cpu_rdata_s = ram_rdata;
      end
    end else begin
      cpu_rdata_s = cpu_hold_r;
      dbg_rdata_s = dbg_hold_r;
    end
    cpu_wait_s = reset & cpu_req & ~cpu_ack_r;
  end

  assign cpu_ack   = cpu_ack_r;
  assign dbg_ack   = dbg_ack_r;
  assign cpu_rdata = cpu_rdata_s;
  assign dbg_rdata = dbg_rdata_s;
  assign ram_read  = ram_read_r;
  assign ram_write = ram_write_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign cpu_wait  = cpu_wait_s;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus queues expected acks, a negedge monitor checks them.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        ram_read, ram_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        cpu_wait;

  typedef struct {
    bit          dbg;
    bit          we;
    logic [8:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          st_cyc = -1;
  logic        st_we;
  logic [8:0]  st_addr;
  logic [31:0] st_wdata;
  logic [31:0] mem [512];

  ram_arbiter dut (
    .clk(clk), .reset(reset), .clr(clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .cpu_wait(cpu_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: read data valid the cycle after ram_read.
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_read) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: remember the last RAM strobe, and score every ack against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (ram_read || ram_write) begin
      st_cyc   = cyc;
      st_we    = ram_write;
      st_addr  = ram_addr;
      st_wdata = ram_wdata;
    end
    if (cpu_ack || dbg_ack) begin
      if (sb.size() == 0) begin
        check("spurious_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_pair", {30'd0, cpu_ack, dbg_ack}, e.dbg ? 32'd1 : 32'd2);
        check("ack_cycle", cyc, e.cyc);
        check("strobe_cycle", st_cyc, e.cyc - 1);
        check("strobe_we", {31'd0, st_we}, {31'd0, e.we});
        check("strobe_addr", {23'd0, st_addr}, {23'd0, e.addr});
        if (e.we) check("strobe_wdata", st_wdata, e.data);
        else check("rdata", e.dbg ? dbg_rdata : cpu_rdata, e.data);
      end
    end
  end

  task automatic start(input bit d, input bit we, input logic [8:0] a,
                       input logic [31:0] data, input int lat);
    exp_t e;
    if (d) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = we ? data : 32'h0;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = we ? data : 32'h0;
    end
    e.dbg = d; e.we = we; e.addr = a; e.data = data; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input bit d);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = d ? dbg_ack : cpu_ack;
    end
    check(d ? "dbg_ack_seen" : "cpu_ack_seen", {31'd0, got}, 32'd1);
    if (d) dbg_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  task automatic access(input bit d, input bit we, input logic [8:0] a, input logic [31:0] data);
    @(negedge clk);
    start(d, we, a, data, 2);
    wait_ack(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    reset = 1'b0; clr = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 9'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 9'h0; dbg_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_strobes_acks", {28'd0, cpu_ack, dbg_ack, ram_read, ram_write}, 32'd0);
    check("rst_ram_addr", {23'd0, ram_addr}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);

    // CPU write right at reset release, then read back.
    @(negedge clk);
    reset = 1'b1;
    start(1'b0, 1'b1, 9'h055, 32'hDEADBEEF, 2);
    wait_ack(1'b0);
    access(1'b0, 1'b0, 9'h055, 32'hDEADBEEF);
    @(negedge clk);
    check("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // Debug loads 0x1FF then reads it back; CPU hold must not move.
    access(1'b1, 1'b1, 9'h1FF, 32'h12345678);
    access(1'b1, 1'b0, 9'h1FF, 32'h12345678);
    @(negedge clk);
    check("cpu_rdata_after_dbg", cpu_rdata, 32'hDEADBEEF);
    check("dbg_rdata_hold", dbg_rdata, 32'h12345678);

    // Both held high: CPU x4 then DBG, repeating.
    @(negedge clk);
    n = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h055;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h1FF;
    for (int k = 0; k < 10; k++) begin
      e.dbg  = (k % 5 == 4);
      e.we   = 1'b0;
      e.addr = e.dbg ? 9'h1FF : 9'h055;
      e.data = e.dbg ? 32'h12345678 : 32'hDEADBEEF;
      e.cyc  = n + 2 + 3 * k;
      sb.push_back(e);
    end
    repeat (29) @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Simultaneous request with counter cleared: CPU first, debug right after.
    @(negedge clk);
    start(1'b0, 1'b0, 9'h055, 32'hDEADBEEF, 2);
    start(1'b1, 1'b0, 9'h1FF, 32'h12345678, 5);
    @(negedge clk);
    check("cpu_wait_stall", {31'd0, cpu_wait}, 32'd1);
    @(negedge clk);
    check("cpu_wait_ack", {31'd0, cpu_wait}, 32'd0);
    cpu_req = 1'b0;
    wait_ack(1'b1);

    // clr during ACCESS of a CPU write: aborted, then re-granted from scratch.
    @(negedge clk);
    start(1'b0, 1'b1, 9'h0AA, 32'hCAFEF00D, 4);
    @(negedge clk);
    check("clr_access_strobe", {31'd0, ram_write}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_abort", {29'd0, ram_read, ram_write, cpu_ack}, 32'd0);
    wait_ack(1'b0);
    @(negedge clk);
    check("write_keeps_hold", cpu_rdata, 32'hDEADBEEF);
    access(1'b0, 1'b0, 9'h0AA, 32'hCAFEF00D);

    // Reset mid-RESP of a debug read: outputs clear without waiting for a clock.
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h1FF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("resp_before_reset", {31'd0, dbg_ack}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_ctrl", {27'd0, cpu_ack, dbg_ack, ram_read, ram_write, cpu_wait}, 32'd0);
    check("async_rst_addr", {23'd0, ram_addr}, 32'd0);
    check("async_rst_cpu_rdata", cpu_rdata, 32'd0);
    check("async_rst_dbg_rdata", dbg_rdata, 32'd0);
    @(negedge clk);
    dbg_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    access(1'b0, 1'b0, 9'h055, 32'hDEADBEEF);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, RAM word width.
REQ-002 Parameter ADDR_W, default 9, RAM word-address width (512 words).
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive CPU grants allowed while debug waits.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  synchronous clear from control unit, active-high.
REQ-007 cpu_req / cpu_we  in  1/1  CPU access request / write-not-read.
REQ-008 cpu_addr / cpu_wdata  in  ADDR_W/DATA_W  CPU address (MAR) / write data (MDR).
REQ-009 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-010 cpu_rdata  out  DATA_W  CPU read data (feeds Mdatain).
REQ-011 dbg_req / dbg_we  in  1/1  debug/loader request / write-not-read.
REQ-012 dbg_addr / dbg_wdata  in  ADDR_W/DATA_W  debug address / write data.
REQ-013 dbg_ack  out  1  one-cycle completion pulse to debug port.
REQ-014 dbg_rdata  out  DATA_W  debug read data.
REQ-015 ram_read / ram_write  out  1/1  registered RAM strobes.
REQ-016 ram_addr / ram_wdata  out  ADDR_W/DATA_W  registered RAM address / write data.
REQ-017 ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_read.
REQ-018 cpu_wait  out  1  cpu_req high and cpu_ack low (combinational stall to control unit).

Function
REQ-019 FSM states: IDLE, ACCESS, RESP; owner register {CPU, DBG} latched on grant.
REQ-020 Requests sampled only in IDLE; req/we/addr/wdata held stable by requester until its ack.
REQ-021 IDLE, any req -> ACCESS next cycle; ACCESS -> RESP unconditionally; RESP -> IDLE unconditionally.
REQ-022 On grant edge, ram_addr/ram_wdata load from owner; ram_read = ~we, ram_write = we, asserted only during ACCESS.
REQ-023 Owner's ack high only during RESP; exactly one ack per granted access.
REQ-024 Latency: req seen in IDLE cycle N -> RAM strobe cycle N+1 -> ack cycle N+2; next grant earliest N+3.
REQ-025 During RESP of a read, owner's rdata = ram_rdata; hold register loads at end of RESP; outside RESP rdata = hold value.
REQ-026 Write accesses leave both rdata hold registers unchanged; non-owner rdata never changes.
REQ-027 Arbitration: only one requester -> it wins; both -> CPU wins unless starve_cnt == STARVE_LIMIT, then DBG wins.
REQ-028 starve_cnt (saturating at STARVE_LIMIT): +1 on CPU grant while dbg_req high; cleared on DBG grant or when dbg_req low in IDLE.
REQ-029 A request still high during its own RESP cycle is ignored; it is re-sampled in the following IDLE.
REQ-030 clr high: next state IDLE, ram strobes low, starve_cnt 0, in-flight access aborted with no ack; hold registers unchanged.
REQ-031 Address and data pass unmodified; no range checking.

Reset
REQ-032 reset low: immediately state IDLE, owner CPU, starve_cnt 0, all outputs and hold registers 0, independent of clk.
REQ-033 Reset asserted mid-access: no ack issued; after release, arbiter samples requests fresh in IDLE.
REQ-034 First grant possible on first rising edge after reset deasserts.

Verification
REQ-035 CPU write addr 0x055 data 0xDEADBEEF, then read 0x055 -> ram_write pulse cycle N+1, cpu_ack N+2; read returns 0xDEADBEEF with cpu_ack, cpu_rdata holds it afterwards.
REQ-036 dbg_req only, read 0x1FF holding 0x12345678 -> dbg_ack at N+2, dbg_rdata 0x12345678, cpu_rdata unchanged.
REQ-037 cpu_req and dbg_req continuously high, STARVE_LIMIT=4 -> grant order CPU,CPU,CPU,CPU,DBG repeating; every 5th ack is dbg_ack.
REQ-038 Both request in same IDLE with starve_cnt 0 -> CPU granted; cpu_wait low only in CPU's ack cycle; dbg_ack after CPU completes.
REQ-039 clr pulsed during ACCESS of CPU write -> no cpu_ack, state IDLE next cycle, still-high cpu_req re-granted with full 3-cycle latency.
REQ-040 reset driven low mid-RESP between clock edges -> all outputs 0 before next edge; no ack; normal operation after release.
